// File: rtl/div_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the RV32M divide sequencer.
package div_ctrl_pkg;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_CNT_W = 5;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        DIV_STATE_IDLE = 2'd0,
        DIV_STATE_CALC = 2'd1,
        DIV_STATE_END  = 2'd2
    } div_state_e;

    // Decode helper for ex: true for DIV/DIVU/REM/REMU encodings.
    function automatic logic div_is_div_op(input logic [6:0] funct7, input logic [2:0] funct3);
        return (funct7 == FUNCT7_MULDIV) && funct3[2];
    endfunction

    function automatic logic [DIV_XLEN-1:0] div_abs(input logic [DIV_XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[DIV_XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response bundle between ex (master) and the divide sequencer (slave).
interface div_ctrl_if;
    import div_ctrl_pkg::*;

    logic                start_i;
    logic [2:0]          op_i;
    logic [DIV_XLEN-1:0] dividend_i;
    logic [DIV_XLEN-1:0] divisor_i;
    logic [4:0]          reg_waddr_i;
    logic                abort_i;
    logic                busy_o;
    logic                ready_o;
    logic [DIV_XLEN-1:0] result_o;
    logic [4:0]          reg_waddr_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, abort_i,
        input  busy_o, ready_o, result_o, reg_waddr_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, abort_i,
        output busy_o, ready_o, result_o, reg_waddr_o
    );

endinterface

// File: rtl/div_ctrl_step.sv
// One restoring radix-2 iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dvd_bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0] shifted;

    // The shifted remainder can exceed XLEN bits, so compare at XLEN+1; the difference always fits in XLEN.
    always_comb begin
        shifted = {rem_i, dvd_bit_i};
        q_bit_o = (shifted >= {1'b0, divisor_i});
        rem_o   = q_bit_o ? (shifted[XLEN-1:0] - divisor_i) : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer beside ex; one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = DIV_CNT_W
) (
    input logic       clk,
    input logic       rst,
    div_ctrl_if.slave bus
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  dq_q, dq_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             ready_q, ready_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [4:0]       waddr_q, waddr_d;

    logic             op_signed;
    logic             op_rem;
    logic [XLEN-1:0]  dvd_abs;
    logic [XLEN-1:0]  dvs_abs;
    logic             div_zero;
    logic             div_ovf;
    logic [XLEN-1:0]  step_rem;
    logic             step_q;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dq_q[XLEN-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    always_comb begin
        op_signed = !((bus.op_i == FUNCT3_DIVU) || (bus.op_i == FUNCT3_REMU));
        op_rem    = (bus.op_i == FUNCT3_REM) || (bus.op_i == FUNCT3_REMU);
        dvd_abs   = div_abs(bus.dividend_i, op_signed);
        dvs_abs   = div_abs(bus.divisor_i, op_signed);
        div_zero  = (bus.divisor_i == '0);
        div_ovf   = op_signed && (bus.dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (bus.divisor_i == '1);
    end

    // dq holds the shrinking dividend in its upper bits and the growing quotient in its lower bits.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dq_d      = dq_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        ready_d   = 1'b0;
        result_d  = result_q;
        waddr_d   = waddr_q;

        case (state_q)
            DIV_STATE_IDLE: begin
                if (bus.start_i) begin
                    waddr_d   = bus.reg_waddr_i;
                    is_rem_d  = op_rem;
                    neg_quo_d = op_signed && (bus.dividend_i[XLEN-1] ^ bus.divisor_i[XLEN-1]);
                    neg_rem_d = op_signed && bus.dividend_i[XLEN-1];
                    dvs_d     = dvs_abs;
                    cnt_d     = '0;
                    // Special results are already final, so the sign fix is disabled for them.
                    if (div_zero) begin
                        dq_d      = '1;
                        rem_d     = bus.dividend_i;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = DIV_STATE_END;
                    end else if (div_ovf) begin
                        dq_d      = {1'b1, {(XLEN-1){1'b0}}};
                        rem_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = DIV_STATE_END;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (dvd_abs < dvs_abs) begin
                        dq_d    = '0;
                        rem_d   = dvd_abs;
                        state_d = DIV_STATE_END;
                    end
`endif
                    else begin
                        dq_d    = dvd_abs;
                        rem_d   = '0;
                        state_d = DIV_STATE_CALC;
                    end
                end
            end
            DIV_STATE_CALC: begin
                dq_d  = {dq_q[XLEN-2:0], step_q};
                rem_d = step_rem;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == '1) begin
                    state_d = DIV_STATE_END;
                end
            end
            DIV_STATE_END: begin
                if (is_rem_q) begin
                    result_d = neg_rem_q ? -rem_q : rem_q;
                end else begin
                    result_d = neg_quo_q ? -dq_q : dq_q;
                end
                ready_d = 1'b1;
                state_d = DIV_STATE_IDLE;
            end
            default: begin
                state_d = DIV_STATE_IDLE;
            end
        endcase

        // A flush cancels everything in flight, including an accept in the same cycle.
        if (bus.abort_i) begin
            state_d  = DIV_STATE_IDLE;
            ready_d  = 1'b0;
            result_d = result_q;
            waddr_d  = waddr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_STATE_IDLE;
            cnt_q     <= '0;
            dq_q      <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
            waddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dq_q      <= dq_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
            waddr_q   <= waddr_d;
        end
    end

    assign bus.busy_o      = (state_q != DIV_STATE_IDLE);
    assign bus.ready_o     = ready_q;
    assign bus.result_o    = result_q;
    assign bus.reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed vector table, random ops against an arithmetic model, and corner sequences.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic [31:0] last_expected;

    always #5 clk = ~clk;

    div_ctrl_if bus();

    div_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issues one op from an idle DUT and waits (bounded) for ready_o; lat = -1 on timeout.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] waddr, output logic [31:0] res, output int lat,
                                 output logic [4:0] waddr_out);
        bus.start_i     = 1'b1;
        bus.abort_i     = 1'b0;
        bus.op_i        = op;
        bus.dividend_i  = a;
        bus.divisor_i   = b;
        bus.reg_waddr_i = waddr;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.ready_o) begin
                lat = c;
                break;
            end
        end
        res       = bus.result_o;
        waddr_out = bus.reg_waddr_o;
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (op)
            FUNCT3_DIV:  return (b == 0) ? 32'hFFFFFFFF : (ovf ? 32'h80000000 : 32'(sa / sb));
            FUNCT3_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
            FUNCT3_REM:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default:     return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic   sgn;
        longint ma;
        longint mb;
        sgn = (op == FUNCT3_DIV) || (op == FUNCT3_REM);
        if (b == 0) return 1;
        if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        if (sgn) begin
            ma = longint'($signed(a));
            mb = longint'($signed(b));
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end else begin
            ma = longint'({32'b0, a});
            mb = longint'({32'b0, b});
        end
        if (ma < mb) return EARLY_LAT;
        return 33;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[14];
        logic [31:0] res;
        logic [4:0]  wout;
        int          lat;
        int          seen;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{"divu_100_7",    FUNCT3_DIVU, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{"remu_100_7",    FUNCT3_REMU, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{"div_m7_2",      FUNCT3_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33};
        vecs[3]  = '{"rem_m7_2",      FUNCT3_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33};
        vecs[4]  = '{"rem_7_m2",      FUNCT3_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          33};
        vecs[5]  = '{"div_x_0",       FUNCT3_DIV,  32'd1234,       32'd0,          32'hFFFFFFFF,   1};
        vecs[6]  = '{"remu_5_0",      FUNCT3_REMU, 32'd5,          32'd0,          32'd5,          1};
        vecs[7]  = '{"rem_m5_0",      FUNCT3_REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1};
        vecs[8]  = '{"div_ovf",       FUNCT3_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
        vecs[9]  = '{"rem_ovf",       FUNCT3_REM,  32'h80000000,   32'hFFFFFFFF,   32'h0,          1};
        vecs[10] = '{"divu_3_9",      FUNCT3_DIVU, 32'd3,          32'd9,          32'd0,          EARLY_LAT};
        vecs[11] = '{"rem_m3_9",      FUNCT3_REM,  32'hFFFFFFFD,   32'd9,          32'hFFFFFFFD,   EARLY_LAT};
        vecs[12] = '{"divu_max_1",    FUNCT3_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33};
        vecs[13] = '{"divu_max_max",  FUNCT3_DIVU, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          33};

        bus.start_i     = 1'b0;
        bus.abort_i     = 1'b0;
        bus.op_i        = '0;
        bus.dividend_i  = '0;
        bus.divisor_i   = '0;
        bus.reg_waddr_i = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_busy",  32'(bus.busy_o), 32'd0);
        checkOutput("reset_ready", 32'(bus.ready_o), 32'd0);
        checkOutput("reset_result", bus.result_o, 32'd0);
        checkOutput("reset_waddr", 32'(bus.reg_waddr_o), 32'd0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), res, lat, wout);
            checkOutput({vecs[i].name, "_result"}, res, vecs[i].exp_res);
            checkOutput({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            checkOutput({vecs[i].name, "_waddr"}, 32'(wout), 32'(i + 1));
            @(posedge clk); #1;
            checkOutput({vecs[i].name, "_ready_single"}, 32'(bus.ready_o), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 3'(4 + $urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: ra = $urandom_range(0, 20);
                3: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                4: rb = -($urandom_range(1, 15));
                default: ;
            endcase
            applyStimulus(rop, ra, rb, 5'(i), res, lat, wout);
            checkOutput($sformatf("rand%0d_result", i), res, ref_result(rop, ra, rb));
            checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_latency(rop, ra, rb)));
            last_expected = ref_result(rop, ra, rb);
            @(posedge clk); #1;
        end

        // Abort while CALC holds cnt=10: back to IDLE, no ready_o, result_o untouched.
        bus.start_i = 1'b1; bus.op_i = FUNCT3_DIVU; bus.dividend_i = 32'd1000;
        bus.divisor_i = 32'd3; bus.reg_waddr_i = 5'd9;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.abort_i = 1'b1;
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        checkOutput("abort_busy", 32'(bus.busy_o), 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.ready_o) seen++;
        end
        checkOutput("abort_no_ready", 32'(seen), 32'd0);
        checkOutput("abort_result_held", bus.result_o, last_expected);

        // start_i held high through the op: ignored while busy, accepted in the ready_o cycle.
        bus.start_i = 1'b1; bus.op_i = FUNCT3_DIVU; bus.dividend_i = 32'd1000;
        bus.divisor_i = 32'd10; bus.reg_waddr_i = 5'd3;
        @(posedge clk); #1;
        bus.dividend_i = 32'd77; bus.divisor_i = 32'd7; bus.reg_waddr_i = 5'd4;
        checkOutput("held_busy", 32'(bus.busy_o), 32'd1);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.ready_o) begin lat = c; break; end
        end
        checkOutput("held_latency", 32'(lat), 32'd33);
        checkOutput("held_result", bus.result_o, 32'd100);
        checkOutput("held_waddr", 32'(bus.reg_waddr_o), 32'd3);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        checkOutput("b2b_ready_not_consec", 32'(bus.ready_o), 32'd0);
        checkOutput("b2b_busy", 32'(bus.busy_o), 32'd1);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.ready_o) begin lat = c; break; end
        end
        checkOutput("b2b_latency", 32'(lat), 32'd33);
        checkOutput("b2b_result", bus.result_o, 32'd11);
        checkOutput("b2b_waddr", 32'(bus.reg_waddr_o), 32'd4);
        @(posedge clk); #1;

        // abort_i beats start_i in the same cycle.
        bus.start_i = 1'b1; bus.abort_i = 1'b1; bus.divisor_i = 32'd0;
        @(posedge clk); #1;
        bus.start_i = 1'b0; bus.abort_i = 1'b0;
        checkOutput("abort_start_busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;
        checkOutput("abort_start_ready", 32'(bus.ready_o), 32'd0);

        // Reset mid-operation behaves like power-on reset.
        bus.start_i = 1'b1; bus.op_i = FUNCT3_DIV; bus.dividend_i = 32'd100;
        bus.divisor_i = 32'd3; bus.reg_waddr_i = 5'd7;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("midrst_ready", 32'(bus.ready_o), 32'd0);
        checkOutput("midrst_result", bus.result_o, 32'd0);
        checkOutput("midrst_waddr", 32'(bus.reg_waddr_o), 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.ready_o) seen++;
        end
        checkOutput("midrst_no_ready", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
